fetch_sequencer: RTL and testbench

- Sequences the combinational program memory (8-bit address in, 16-bit instruction out).
- Owns the program counter and instruction register.
- Hands each fetched instruction to the control unit over a valid/ready handshake.
- Applies jumps at instruction retirement, and stops fetching when it fetches a STOP instruction.

---
 rtl/fetch_sequencer_pkg.sv | 18 +
 rtl/fetch_sequencer_pc_reg.sv | 27 ++
 rtl/fetch_sequencer.sv | 101 ++++++++++
 tb/tb_fetch_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared constants for the fetch sequencer: widths, STOP opcode field and FSM state encoding.
package fetch_sequencer_pkg;

  localparam int AW     = 8;
  localparam int DW     = 16;
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 11;

  localparam logic [OPC_HI-OPC_LO:0] STOP_OPC = 5'b10111;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_FETCH = 2'd1;
  localparam state_t S_ISSUE = 2'd2;
  localparam state_t S_HALT  = 2'd3;

endpackage

// File: rtl/fetch_sequencer_pc_reg.sv
// Program counter: load has priority over increment; increment wraps modulo 2^AW.
module fetch_sequencer_pc_reg
  import fetch_sequencer_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic          inc,
  input  logic [AW-1:0] load_val,
  output logic [AW-1:0] pc
);

  logic [AW-1:0] r_pc;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pc <= '0;
    end else if (load) begin
      r_pc <= load_val;
    end else if (inc) begin
      r_pc <= r_pc + AW'(1);
    end
  end

  assign pc = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: FETCH latches the program word, ISSUE offers it to the control unit
// over valid/ready; a fetched STOP word parks the sequencer in HALT until the next start.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic [DW-1:0] ir,
  output logic          ir_valid,
  input  logic          ir_ready,
  input  logic          jump_en,
  input  logic [AW-1:0] jump_addr,
  output logic          halted,
  output logic          busy,
  output logic [15:0]   retired
);

  state_t        r_state;
  logic [DW-1:0] r_ir;
  logic          r_halted;
  logic [15:0]   r_retired;

  logic          w_is_stop;
  logic          w_hs;
  logic          w_start_ok;
  logic          w_jump;
  logic          w_pc_load;
  logic          w_pc_inc;
  logic [AW-1:0] w_pc_val;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_is_stop  = (mem_data[OPC_HI:OPC_LO] == STOP_OPC);
  assign w_hs       = (r_state == S_ISSUE) && ir_ready;
  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_HALT));
  assign w_jump     = w_hs && jump_en;

  // start and a jump can never coincide: start is only accepted outside ISSUE
  assign w_pc_load  = w_start_ok || w_jump;
  assign w_pc_val   = w_jump ? jump_addr : start_addr;
  assign w_pc_inc   = (r_state == S_FETCH) && !w_is_stop;

  fetch_sequencer_pc_reg u_pc (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (w_pc_load),
    .inc      (w_pc_inc),
    .load_val (w_pc_val),
    .pc       (mem_addr)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_ir      <= '0;
      r_halted  <= 1'b0;
      r_retired <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_ir <= mem_data;
          if (w_is_stop) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else begin
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (ir_ready) begin
            r_retired <= sat_inc(r_retired);
            r_state   <= S_FETCH;
          end
        end
        S_HALT: begin
          if (start) begin
            r_halted <= 1'b0;
            r_state  <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ir       = r_ir;
  assign ir_valid = (r_state == S_ISSUE);
  assign halted   = r_halted;
  assign busy     = (r_state == S_FETCH) || (r_state == S_ISSUE);
  assign retired  = r_retired;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed per-cycle vector table, then randomized programs
// checked against an instruction-stream scoreboard.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  start_addr;
  logic [7:0]  mem_addr;
  logic [15:0] mem_data;
  logic [15:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic        jump_en;
  logic [7:0]  jump_addr;
  logic        halted;
  logic        busy;
  logic [15:0] retired;

  logic [15:0] mem [0:255];

  int errs;
  int checks;

  assign mem_data = mem[mem_addr];

  fetch_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .start_addr (start_addr),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .halted     (halted),
    .busy       (busy),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        st;
    logic [7:0]  sa;
    logic        rdy;
    logic        jen;
    logic [7:0]  ja;
    logic        v;
    logic [15:0] ir;
    logic [7:0]  ma;
    logic        h;
    logic        b;
    logic [15:0] ret;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic row(input logic rn, input logic st, input logic [7:0] sa, input logic rdy,
                     input logic jen, input logic [7:0] ja, input logic v, input logic [15:0] eir,
                     input logic [7:0] ma, input logic h, input logic b, input logic [15:0] ret);
    vec_t r;
    r.rst_n = rn; r.st = st; r.sa = sa; r.rdy = rdy; r.jen = jen; r.ja = ja;
    r.v = v; r.ir = eir; r.ma = ma; r.h = h; r.b = b; r.ret = ret;
    tbl.push_back(r);
  endtask

  function automatic logic is_stop(input logic [15:0] w);
    return w[15:11] == 5'b10111;
  endfunction

  initial begin
    logic [7:0]  exp_addr;
    logic [7:0]  nxt;
    logic [15:0] exp_ret;
    int          hs;
    logic        done;

    errs = 0; checks = 0;
    reset_n = 1'b0; start = 1'b0; start_addr = '0;
    ir_ready = 1'b0; jump_en = 1'b0; jump_addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'hF8AA; mem[1] = 16'h1080; mem[2] = 16'h1983;
    mem[3] = 16'h1181; mem[4] = 16'hB800; mem[255] = 16'h1234;

    // rn st sa rdy jen ja | v ir ma h b ret
    // program run with ready high, then restart from HALT at 0x02
    row(1,1,8'h00,1,0,8'h00, 0,16'h0000,8'h00,0,1,0);
    row(1,0,8'h00,1,0,8'h00, 1,16'hF8AA,8'h01,0,1,0);
    row(1,0,8'h00,1,0,8'h00, 0,16'hF8AA,8'h01,0,1,1);
    row(1,0,8'h00,1,0,8'h00, 1,16'h1080,8'h02,0,1,1);
    row(1,0,8'h00,1,0,8'h00, 0,16'h1080,8'h02,0,1,2);
    row(1,0,8'h00,1,0,8'h00, 1,16'h1983,8'h03,0,1,2);
    row(1,0,8'h00,1,0,8'h00, 0,16'h1983,8'h03,0,1,3);
    row(1,0,8'h00,1,0,8'h00, 1,16'h1181,8'h04,0,1,3);
    row(1,0,8'h00,1,0,8'h00, 0,16'h1181,8'h04,0,1,4);
    row(1,0,8'h00,1,0,8'h00, 0,16'hB800,8'h04,1,0,4);
    row(1,0,8'h00,1,1,8'h01, 0,16'hB800,8'h04,1,0,4);
    row(1,1,8'h02,1,0,8'h00, 0,16'hB800,8'h02,0,1,4);
    row(1,0,8'h00,1,0,8'h00, 1,16'h1983,8'h03,0,1,4);
    row(1,0,8'h00,1,0,8'h00, 0,16'h1983,8'h03,0,1,5);
    row(1,0,8'h00,1,0,8'h00, 1,16'h1181,8'h04,0,1,5);
    row(1,0,8'h00,1,0,8'h00, 0,16'h1181,8'h04,0,1,6);
    row(1,0,8'h00,1,0,8'h00, 0,16'hB800,8'h04,1,0,6);
    // backpressure on the second ISSUE, stray start/jump ignored, then jump to STOP
    row(0,0,8'h00,0,0,8'h00, 0,16'h0000,8'h00,0,0,0);
    row(1,1,8'h00,0,0,8'h00, 0,16'h0000,8'h00,0,1,0);
    row(1,0,8'h00,0,0,8'h00, 1,16'hF8AA,8'h01,0,1,0);
    row(1,0,8'h00,1,0,8'h00, 0,16'hF8AA,8'h01,0,1,1);
    row(1,0,8'h00,0,0,8'h00, 1,16'h1080,8'h02,0,1,1);
    row(1,0,8'h00,0,0,8'h00, 1,16'h1080,8'h02,0,1,1);
    row(1,1,8'h40,0,0,8'h00, 1,16'h1080,8'h02,0,1,1);
    row(1,0,8'h00,0,1,8'h00, 1,16'h1080,8'h02,0,1,1);
    row(1,0,8'h00,0,0,8'h00, 1,16'h1080,8'h02,0,1,1);
    row(1,0,8'h00,0,0,8'h00, 1,16'h1080,8'h02,0,1,1);
    row(1,0,8'h00,1,1,8'h04, 0,16'h1080,8'h04,0,1,2);
    row(1,0,8'h00,1,0,8'h00, 0,16'hB800,8'h04,1,0,2);
    // reset while in ISSUE after an ignored start
    row(0,0,8'h00,0,0,8'h00, 0,16'h0000,8'h00,0,0,0);
    row(1,1,8'h00,0,0,8'h00, 0,16'h0000,8'h00,0,1,0);
    row(1,0,8'h00,0,0,8'h00, 1,16'hF8AA,8'h01,0,1,0);
    row(1,1,8'h03,0,0,8'h00, 1,16'hF8AA,8'h01,0,1,0);
    row(0,1,8'h03,1,1,8'h07, 0,16'h0000,8'h00,0,0,0);
    row(1,0,8'h00,0,0,8'h00, 0,16'h0000,8'h00,0,0,0);
    // PC wrap from 0xFF
    row(1,1,8'hFF,0,0,8'h00, 0,16'h0000,8'hFF,0,1,0);
    row(1,0,8'h00,0,0,8'h00, 1,16'h1234,8'h00,0,1,0);
    row(1,0,8'h00,1,0,8'h00, 0,16'h1234,8'h00,0,1,1);
    row(1,0,8'h00,0,0,8'h00, 1,16'hF8AA,8'h01,0,1,1);

    repeat (2) @(negedge clk);
    chk("reset ir_valid", 32'(ir_valid), 32'd0);
    chk("reset ir", 32'(ir), 32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    chk("reset halted", 32'(halted), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset retired", 32'(retired), 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      reset_n = tbl[i].rst_n; start = tbl[i].st; start_addr = tbl[i].sa;
      ir_ready = tbl[i].rdy; jump_en = tbl[i].jen; jump_addr = tbl[i].ja;
      @(negedge clk);
      chk($sformatf("row%0d ir_valid", i), 32'(ir_valid), 32'(tbl[i].v));
      chk($sformatf("row%0d ir", i), 32'(ir), 32'(tbl[i].ir));
      chk($sformatf("row%0d mem_addr", i), 32'(mem_addr), 32'(tbl[i].ma));
      chk($sformatf("row%0d halted", i), 32'(halted), 32'(tbl[i].h));
      chk($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].b));
      chk($sformatf("row%0d retired", i), 32'(retired), 32'(tbl[i].ret));
    end

    // Randomized programs: the model tracks only which address the next retired
    // instruction comes from and how many have retired.
    for (int run = 0; run < 20; run++) begin
      for (int a = 0; a < 256; a++) begin
        logic [15:0] w;
        w = 16'($urandom);
        if ($urandom_range(7) == 0) w[15:11] = 5'b10111;
        else if (is_stop(w)) w[11] = 1'b0;
        mem[a] = w;
      end
      reset_n = 1'b0; start = 1'b0; ir_ready = 1'b0; jump_en = 1'b0;
      @(negedge clk);
      reset_n = 1'b1; start = 1'b1; start_addr = 8'($urandom);
      exp_addr = start_addr; exp_ret = '0; hs = 0; done = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
        @(negedge clk);
        if (halted) begin
          chk("rnd halt ir", 32'(ir), 32'(mem[exp_addr]));
          chk("rnd halt mem_addr", 32'(mem_addr), 32'(exp_addr));
          chk("rnd halt retired", 32'(retired), 32'(exp_ret));
          chk("rnd halt ir_valid", 32'(ir_valid), 32'd0);
          done = 1'b1;
        end else begin
          if (ir_valid) begin
            nxt = exp_addr + 8'd1;
            chk("rnd ir", 32'(ir), 32'(mem[exp_addr]));
            chk("rnd mem_addr", 32'(mem_addr), 32'(nxt));
            chk("rnd retired", 32'(retired), 32'(exp_ret));
          end
          ir_ready  = 1'($urandom_range(1));
          jump_en   = ($urandom_range(3) == 0);
          jump_addr = 8'($urandom);
          if (ir_valid && ir_ready) begin
            exp_addr = jump_en ? jump_addr : exp_addr + 8'd1;
            exp_ret  = exp_ret + 16'd1;
            hs++;
          end
        end
      end
      if (!done && hs == 0) begin
        checks++;
        errs++;
        $display("FAIL rnd progress: got 0 handshakes and no halt, required progress in run %0d", run);
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
